// File: rtl/axi_lite_test_master_if.sv
// AXI4-Lite bus bundle between the test master and its point-to-point slave.
interface axi_lite_test_master_if #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DataWidth = 32
) ();

  logic [AddrWidth-1:0]   aw_addr;
  logic [2:0]             aw_prot;
  logic                   aw_valid;
  logic                   aw_ready;
  logic [DataWidth-1:0]   w_data;
  logic [DataWidth/8-1:0] w_strb;
  logic                   w_valid;
  logic                   w_ready;
  logic [1:0]             b_resp;
  logic                   b_valid;
  logic                   b_ready;
  logic [AddrWidth-1:0]   ar_addr;
  logic [2:0]             ar_prot;
  logic                   ar_valid;
  logic                   ar_ready;
  logic [DataWidth-1:0]   r_data;
  logic [1:0]             r_resp;
  logic                   r_valid;
  logic                   r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
    output ar_addr, ar_prot, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
    input  ar_addr, ar_prot, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

endinterface

// File: rtl/axi_lite_test_master.sv
// AXI4-Lite self-test master: writes a seeded pattern to each slave register, reads it
// back, and counts mismatches and non-OKAY responses.
module axi_lite_test_master #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_NUM_REGS         = 4,
  parameter logic [31:0] C_DATA_SEED        = 32'hA5A5_0000
) (
  input  logic                   M_AXI_ACLK,
  input  logic                   M_AXI_ARESET,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [7:0]             err_cnt,
  axi_lite_test_master_if.master m_axi
);

  localparam int unsigned AddrLsb = (C_M_AXI_DATA_WIDTH == 64) ? 3 : 2;
  localparam int unsigned IdxW    = $clog2(C_NUM_REGS + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(C_NUM_REGS - 1);

  typedef enum logic [2:0] {StIdle, StWr, StWrResp, StRd, StRdData, StDone} state_e;

  function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] addr_of(input logic [IdxW-1:0] i);
    return C_M_AXI_ADDR_WIDTH'(i) << AddrLsb;
  endfunction

  // Sum is formed at 32 bits, then zero-extended to the bus width.
  function automatic logic [C_M_AXI_DATA_WIDTH-1:0] pattern_of(input logic [IdxW-1:0] i);
    logic [31:0] sum;
    sum = C_DATA_SEED + 32'(i);
    return C_M_AXI_DATA_WIDTH'(sum);
  endfunction

  state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d, idx_nxt;
  logic aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic b_ready_q, b_ready_d, ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic aw_hs, w_hs, err_inc;

  assign idx_nxt = idx_q + IdxW'(1);
  assign aw_hs   = aw_valid_q && m_axi.aw_ready;
  assign w_hs    = w_valid_q && m_axi.w_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    b_ready_d  = b_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    aw_addr_d  = aw_addr_q;
    ar_addr_d  = ar_addr_q;
    w_data_d   = w_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    err_cnt_d  = err_cnt_q;
    err_inc    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StWr;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_cnt_d  = '0;
          idx_d      = '0;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          aw_addr_d  = addr_of('0);
          w_data_d   = pattern_of('0);
        end
      end
      StWr: begin
        if (aw_hs) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_hs) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = StWrResp;
          b_ready_d = 1'b1;
        end
      end
      StWrResp: begin
        if (m_axi.b_valid && b_ready_q) begin
          b_ready_d = 1'b0;
          err_inc   = (m_axi.b_resp != 2'b00);
          if (idx_q == LastIdx) begin
            idx_d      = '0;
            state_d    = StRd;
            ar_valid_d = 1'b1;
            ar_addr_d  = addr_of('0);
          end else begin
            idx_d      = idx_nxt;
            state_d    = StWr;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            aw_addr_d  = addr_of(idx_nxt);
            w_data_d   = pattern_of(idx_nxt);
          end
        end
      end
      StRd: begin
        if (ar_valid_q && m_axi.ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = StRdData;
        end
      end
      StRdData: begin
        if (m_axi.r_valid && r_ready_q) begin
          r_ready_d = 1'b0;
          err_inc   = (m_axi.r_resp != 2'b00) || (m_axi.r_data != pattern_of(idx_q));
          if (idx_q == LastIdx) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d      = idx_nxt;
            state_d    = StRd;
            ar_valid_d = 1'b1;
            ar_addr_d  = addr_of(idx_nxt);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Error flag is sticky for the pass; the counter saturates.
    if (err_inc) begin
      error_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_addr_q  <= '0;
      ar_addr_q  <= '0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      aw_addr_q  <= aw_addr_d;
      ar_addr_q  <= ar_addr_d;
      w_data_q   <= w_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign m_axi.aw_addr  = aw_addr_q;
  assign m_axi.aw_prot  = 3'b000;
  assign m_axi.aw_valid = aw_valid_q;
  assign m_axi.w_data   = w_data_q;
  assign m_axi.w_strb   = '1;
  assign m_axi.w_valid  = w_valid_q;
  assign m_axi.b_ready  = b_ready_q;
  assign m_axi.ar_addr  = ar_addr_q;
  assign m_axi.ar_prot  = 3'b000;
  assign m_axi.ar_valid = ar_valid_q;
  assign m_axi.r_ready  = r_ready_q;

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_axi_lite_test_master.sv
// Bench for axi_lite_test_master: behavioural 4-register slave with configurable ready
// delays and fault injection; handshakes and final results checked against queued expectations.
module tb_axi_lite_test_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, error;
  logic [7:0] err_cnt;

  axi_lite_test_master_if #(.AddrWidth(4), .DataWidth(32)) bus ();

  axi_lite_test_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(4),
    .C_NUM_REGS        (4),
    .C_DATA_SEED       (32'hA5A5_0000)
  ) dut (
    .M_AXI_ACLK  (clk),
    .M_AXI_ARESET(rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_cnt     (err_cnt),
    .m_axi       (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cnt;
    logic       err;
  } res_t;

  localparam logic [31:0] PAT [4] = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
  localparam logic [3:0]  ADR [4] = '{4'h0, 4'h4, 4'h8, 4'hC};

  logic [3:0]  exp_aw_q [$];
  logic [31:0] exp_w_q  [$];
  logic [3:0]  exp_ar_q [$];
  res_t        exp_res_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_aw     = 0;
  int n_ar     = 0;
  int aw_delay = 0;
  int w_delay  = 0;
  int bresp_err_idx = -1;
  int rdata_xor_idx = -1;
  bit hold_b = 1'b0;
  logic [31:0] mem [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural slave: handshakes are sampled at negedge, responses driven #1 after posedge.
  initial begin : slave
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w;
    int aw_cnt, w_cnt;
    logic [3:0]  waddr, raddr;
    logic [31:0] wdata, exp_v;
    got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0;
    waddr = '0; raddr = '0; wdata = '0;
    bus.aw_ready = 0; bus.w_ready = 0; bus.b_valid = 0; bus.b_resp = 0;
    bus.ar_ready = 0; bus.r_valid = 0; bus.r_data = 0; bus.r_resp = 0;
    foreach (mem[i]) mem[i] = '0;
    forever begin
      @(negedge clk);
      aw_hs = bus.aw_valid && bus.aw_ready;
      w_hs  = bus.w_valid && bus.w_ready;
      b_hs  = bus.b_valid && bus.b_ready;
      ar_hs = bus.ar_valid && bus.ar_ready;
      r_hs  = bus.r_valid && bus.r_ready;
      if (aw_hs) waddr = bus.aw_addr;
      if (w_hs)  wdata = bus.w_data;
      if (ar_hs) raddr = bus.ar_addr;
      @(posedge clk);
      #1;
      if (rst) begin
        got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0;
        bus.aw_ready = 0; bus.w_ready = 0; bus.b_valid = 0;
        bus.ar_ready = 0; bus.r_valid = 0;
        continue;
      end
      if (b_hs) bus.b_valid = 0;
      if (r_hs) bus.r_valid = 0;
      if (aw_hs) begin
        n_aw++;
        chk("aw_valid_drop", bus.aw_valid, 0);
        chk("aw_expected", exp_aw_q.size() != 0, 1);
        if (exp_aw_q.size() != 0) chk("aw_addr", waddr, exp_aw_q.pop_front());
        bus.aw_ready = 0; got_aw = 1; aw_cnt = 0;
      end else if (bus.aw_valid && !got_aw) begin
        if (aw_cnt >= aw_delay) bus.aw_ready = 1;
        else aw_cnt++;
      end
      if (w_hs) begin
        chk("w_valid_drop", bus.w_valid, 0);
        chk("w_expected", exp_w_q.size() != 0, 1);
        if (exp_w_q.size() != 0) chk("w_data", wdata, exp_w_q.pop_front());
        bus.w_ready = 0; got_w = 1; w_cnt = 0;
      end else if (bus.w_valid && !got_w) begin
        if (w_cnt >= w_delay) bus.w_ready = 1;
        else w_cnt++;
      end
      if (got_aw && got_w && !hold_b && !bus.b_valid) begin
        mem[waddr[3:2]] = wdata;
        bus.b_resp  = (int'(waddr[3:2]) == bresp_err_idx) ? 2'b10 : 2'b00;
        bus.b_valid = 1;
        got_aw = 0; got_w = 0;
      end
      if (ar_hs) begin
        n_ar++;
        chk("ar_valid_drop", bus.ar_valid, 0);
        chk("ar_expected", exp_ar_q.size() != 0, 1);
        if (exp_ar_q.size() != 0) chk("ar_addr", raddr, exp_ar_q.pop_front());
        exp_v = (int'(raddr[3:2]) == rdata_xor_idx) ? 32'h1 : 32'h0;
        bus.ar_ready = 0;
        bus.r_data   = mem[raddr[3:2]] ^ exp_v;
        bus.r_resp   = 2'b00;
        bus.r_valid  = 1;
      end else if (bus.ar_valid) begin
        bus.ar_ready = 1;
      end
    end
  end

  // Result monitor: compares the outcome each time done rises.
  initial begin : done_mon
    logic done_prev;
    res_t r;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        chk("res_expected", exp_res_q.size() != 0, 1);
        if (exp_res_q.size() != 0) begin
          r = exp_res_q.pop_front();
          chk("err_cnt", err_cnt, r.cnt);
          chk("error", error, r.err);
          chk("busy_in_done", busy, 0);
        end
      end
      done_prev = done;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_pass(input logic [7:0] exp_cnt, input int extra_starts);
    res_t r;
    bit ok;
    n_aw = 0;
    n_ar = 0;
    for (int i = 0; i < 4; i++) begin
      exp_aw_q.push_back(ADR[i]);
      exp_w_q.push_back(PAT[i]);
      exp_ar_q.push_back(ADR[i]);
    end
    r.cnt = exp_cnt;
    r.err = (exp_cnt != 0);
    exp_res_q.push_back(r);
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("err_cnt_cleared", err_cnt, 0);
    chk("error_cleared", error, 0);
    chk("aw_w_valid_first", {bus.aw_valid, bus.w_valid}, 2'b11);
    for (int k = 0; k < extra_starts; k++) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_reached", ok, 1);
    repeat (3) @(negedge clk);
    chk("writes_seen", n_aw, 4);
    chk("reads_seen", n_ar, 4);
    chk("aw_q_drained", exp_aw_q.size(), 0);
    chk("ar_q_drained", exp_ar_q.size(), 0);
    chk("done_held", done, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit ok;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready}, 0);
    chk("rst_status", {busy, done, error}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_aw_addr", bus.aw_addr, 0);
    chk("rst_ar_addr", bus.ar_addr, 0);
    chk("rst_w_data", bus.w_data, 0);
    chk("prot", {bus.aw_prot, bus.ar_prot}, 0);
    chk("w_strb", bus.w_strb, 4'hF);
    @(negedge clk);
    rst = 1'b0;

    run_pass(8'd0, 0);

    aw_delay = 3; w_delay = 0;
    run_pass(8'd0, 0);
    aw_delay = 0; w_delay = 3;
    run_pass(8'd0, 0);
    w_delay = 0;

    bresp_err_idx = 1; rdata_xor_idx = 2;
    run_pass(8'd2, 0);
    bresp_err_idx = -1; rdata_xor_idx = -1;

    run_pass(8'd0, 2);

    // Stall the first write response, then reset while waiting for it.
    hold_b = 1'b1;
    exp_aw_q.push_back(ADR[0]);
    exp_w_q.push_back(PAT[0]);
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.b_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reached_wr_resp", ok, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valids", {bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready}, 0);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    hold_b = 1'b0;
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_ar_q.delete();
    run_pass(8'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
